// File: rtl/lookup_engine_tcam_pkg.sv
// Shared definitions for the TCAM lookup engine: control header layout,
// table-type codes, control FSM states and a sizing helper.
package lookup_pkg;

  localparam int FLAG_OFF  = 64;
  localparam int MODID_OFF = 112;
  localparam int TYPE_OFF  = 124;
  localparam int INDEX_OFF = 128;

  localparam logic [15:0] CTRL_FLAG = 16'hF1F2;

  localparam logic [3:0] TT_KEY   = 4'd0;
  localparam logic [3:0] TT_ACT   = 4'd1;
  localparam logic [3:0] TT_INVAL = 4'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_MASK,
    ST_ACT,
    ST_FWD,
    ST_DROP
  } ctrl_state_e;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/lookup_engine_tcam_prio_enc.sv
// Priority encoder for a TCAM match vector: the lowest set bit wins.
module tcam_prio_enc #(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [DEPTH-1:0] match,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  // Scanning downwards lets the lowest matching index overwrite the others.
  always_comb begin
    hit   = |match;
    index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lookup_engine_tcam.sv
// Ternary-match lookup stage: 3-cycle key-to-action pipeline with key/mask and
// action tables programmed in-band over the control AXI-Stream.
module lookup_engine_tcam
  import lookup_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int STAGE_ID             = 0,
  parameter int LOOKUP_ID            = 2,
  parameter int PHV_LEN              = 1124,
  parameter int KEY_LEN              = 197,
  parameter int ACT_LEN              = 625,
  parameter int DEPTH                = 16,
  localparam int IDX_W               = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [KEY_LEN-1:0]                extract_key,
  input  logic [KEY_LEN-1:0]                extract_mask,
  input  logic                              key_valid,
  input  logic [PHV_LEN-1:0]                phv_in,
  output logic [ACT_LEN-1:0]                action,
  output logic                              action_valid,
  output logic                              hit,
  output logic [IDX_W-1:0]                  hit_index,
  output logic [PHV_LEN-1:0]                phv_out,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
  input  logic                              c_s_axis_tvalid,
  input  logic                              c_s_axis_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
  output logic                              c_m_axis_tvalid,
  output logic                              c_m_axis_tlast
);

  localparam int DW        = C_S_AXIS_DATA_WIDTH;
  localparam int ACT_BEATS = ceil_div(ACT_LEN, DW);
  localparam int CNT_W     = (ACT_BEATS > 1) ? $clog2(ACT_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACT_BEATS - 1);
  localparam logic [7:0] MOD_ID = {STAGE_ID[4:0], LOOKUP_ID[2:0]};

  logic [KEY_LEN-1:0] key_mem  [DEPTH];
  logic [KEY_LEN-1:0] mask_mem [DEPTH];
  logic [ACT_LEN-1:0] act_mem  [DEPTH];
  logic [DEPTH-1:0]   entry_valid;

  ctrl_state_e             state;
  logic [CNT_W-1:0]        beat_cnt;
  logic [IDX_W-1:0]        tbl_idx;
  logic                    inval_pend;
  logic [KEY_LEN-1:0]      key_buf;
  logic [ACT_BEATS*DW-1:0] act_buf;
  logic [ACT_BEATS*DW-1:0] act_next;

  logic [3:0]       hdr_type;
  logic [7:0]       hdr_index;
  logic             hdr_match;
  logic             hdr_idx_ok;
  logic             hdr_type_ok;
  logic             key_we;
  logic             act_we;
  logic             inval_we;
  logic             fwd_beat;
  logic [IDX_W-1:0] inval_idx;

  logic [DEPTH-1:0]   match_vec;
  logic [DEPTH-1:0]   match_q;
  logic               lk_v1;
  logic               lk_v2;
  logic               enc_hit;
  logic               hit2;
  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W-1:0]   idx2;
  logic [PHV_LEN-1:0] phv1;
  logic [PHV_LEN-1:0] phv2;

  assign hdr_type    = c_s_axis_tdata[TYPE_OFF +: 4];
  assign hdr_index   = c_s_axis_tdata[INDEX_OFF +: 8];
  assign hdr_match   = (c_s_axis_tdata[FLAG_OFF +: 16] == CTRL_FLAG) &&
                       (c_s_axis_tdata[MODID_OFF +: 8] == MOD_ID);
  assign hdr_idx_ok  = {24'd0, hdr_index} < 32'(DEPTH);
  assign hdr_type_ok = (hdr_type == TT_KEY) || (hdr_type == TT_ACT) || (hdr_type == TT_INVAL);

  assign key_we   = c_s_axis_tvalid && (state == ST_MASK);
  assign act_we   = c_s_axis_tvalid && (state == ST_ACT) && (beat_cnt == LAST_BEAT);
  assign fwd_beat = c_s_axis_tvalid && ((state == ST_FWD) || ((state == ST_IDLE) && !hdr_match));

  // A single-beat invalidate packet (header carries tlast) commits straight from IDLE.
  assign inval_we  = c_s_axis_tvalid && c_s_axis_tlast &&
                     (((state == ST_DROP) && inval_pend) ||
                      ((state == ST_IDLE) && hdr_match && hdr_idx_ok && (hdr_type == TT_INVAL)));
  assign inval_idx = (state == ST_IDLE) ? hdr_index[IDX_W-1:0] : tbl_idx;

  always_comb begin
    act_next = act_buf;
    for (int b = 0; b < ACT_BEATS; b++) begin
      if (beat_cnt == CNT_W'(b)) act_next[b*DW +: DW] = c_s_axis_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (key_we) begin
      key_mem[tbl_idx]  <= key_buf;
      mask_mem[tbl_idx] <= c_s_axis_tdata[KEY_LEN-1:0];
    end
    if (act_we) act_mem[tbl_idx] <= act_next[ACT_LEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      beat_cnt        <= '0;
      tbl_idx         <= '0;
      inval_pend      <= 1'b0;
      key_buf         <= '0;
      act_buf         <= '0;
      entry_valid     <= '0;
      c_m_axis_tdata  <= '0;
      c_m_axis_tuser  <= '0;
      c_m_axis_tkeep  <= '0;
      c_m_axis_tvalid <= 1'b0;
      c_m_axis_tlast  <= 1'b0;
    end else begin
      c_m_axis_tvalid <= fwd_beat;
      if (fwd_beat) begin
        c_m_axis_tdata <= c_s_axis_tdata;
        c_m_axis_tuser <= c_s_axis_tuser;
        c_m_axis_tkeep <= c_s_axis_tkeep;
        c_m_axis_tlast <= c_s_axis_tlast;
      end
      if (key_we)   entry_valid[tbl_idx]   <= 1'b1;
      if (inval_we) entry_valid[inval_idx] <= 1'b0;

      if (c_s_axis_tvalid) begin
        case (state)
          ST_IDLE: begin
            if (!hdr_match) begin
              if (!c_s_axis_tlast) state <= ST_FWD;
            end else begin
              tbl_idx    <= hdr_index[IDX_W-1:0];
              beat_cnt   <= '0;
              inval_pend <= 1'b0;
              if (!c_s_axis_tlast) begin
                if (!hdr_idx_ok || !hdr_type_ok) begin
                  state <= ST_DROP;
                end else if (hdr_type == TT_KEY) begin
                  state <= ST_KEY;
                end else if (hdr_type == TT_ACT) begin
                  state <= ST_ACT;
                end else begin
                  state      <= ST_DROP;
                  inval_pend <= 1'b1;
                end
              end
            end
          end
          ST_KEY: begin
            key_buf <= c_s_axis_tdata[KEY_LEN-1:0];
            state   <= c_s_axis_tlast ? ST_IDLE : ST_MASK;
          end
          ST_MASK: state <= c_s_axis_tlast ? ST_IDLE : ST_DROP;
          ST_ACT: begin
            act_buf <= act_next;
            if (c_s_axis_tlast)             state <= ST_IDLE;
            else if (beat_cnt == LAST_BEAT) state <= ST_DROP;
            else                            beat_cnt <= beat_cnt + 1'b1;
          end
          ST_FWD: if (c_s_axis_tlast) state <= ST_IDLE;
          ST_DROP: begin
            if (c_s_axis_tlast) begin
              state      <= ST_IDLE;
              inval_pend <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = entry_valid[i] &&
                     (((extract_key ^ key_mem[i]) & mask_mem[i] & extract_mask) == '0);
    end
  end

  tcam_prio_enc #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_prio (
    .match (match_q),
    .hit   (enc_hit),
    .index (enc_idx)
  );

  // Match, encode and action-read stages; the PHV rides alongside so it lines up with action_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_v1        <= 1'b0;
      match_q      <= '0;
      phv1         <= '0;
      lk_v2        <= 1'b0;
      hit2         <= 1'b0;
      idx2         <= '0;
      phv2         <= '0;
      action_valid <= 1'b0;
      hit          <= 1'b0;
      hit_index    <= '0;
      action       <= '0;
      phv_out      <= '0;
    end else begin
      lk_v1        <= key_valid;
      match_q      <= match_vec;
      phv1         <= phv_in;
      lk_v2        <= lk_v1;
      hit2         <= enc_hit;
      idx2         <= enc_idx;
      phv2         <= phv1;
      action_valid <= lk_v2;
      if (lk_v2) begin
        hit       <= hit2;
        hit_index <= hit2 ? idx2 : '0;
        action    <= hit2 ? act_mem[idx2] : '0;
        phv_out   <= phv2;
      end
    end
  end

endmodule

// File: doc/lookup_engine_tcam.md
Name: lookup_engine_tcam

Overview:
- Parametrised successor of the stage lookup engine in the RMT pipeline.
- Sits between the key extractor and the action engine.
- Holds a DEPTH-entry ternary match table and a DEPTH-entry action RAM.
- Returns the action of the lowest-index matching entry, plus hit and index outputs.
- Tables are programmed in-band over the 256-bit control AXI-Stream. Packets addressed to other modules are forwarded unchanged.

Parameters:
C_S_AXIS_DATA_WIDTH 256 control stream data width
C_S_AXIS_TUSER_WIDTH 128 control stream tuser width
STAGE_ID 0 pipeline stage number (5 bits used)
LOOKUP_ID 2 engine id within stage (3 bits used)
PHV_LEN 1124 PHV width
KEY_LEN 197 key/mask width; must be <= C_S_AXIS_DATA_WIDTH
ACT_LEN 625 action width; ACT_BEATS = ceil(ACT_LEN/C_S_AXIS_DATA_WIDTH)
DEPTH 16 table entries; IDX_W = clog2(DEPTH)

Ports:
clk in 1 clock
rst_n in 1 asynchronous active-low reset
extract_key in KEY_LEN lookup key
extract_mask in KEY_LEN per-request care mask (1 = compare bit)
key_valid in 1 lookup request strobe
phv_in in PHV_LEN PHV accompanying the key
action out ACT_LEN matched action; all zeros on miss
action_valid out 1 result strobe
hit out 1 match found
hit_index out IDX_W index of the winning entry
phv_out out PHV_LEN delayed PHV
c_s_axis_tdata/tuser/tkeep/tvalid/tlast in 256/128/32/1/1 control input stream
c_m_axis_tdata/tuser/tkeep/tvalid/tlast out 256/128/32/1/1 control output stream

Behaviour:
- Reset: all outputs 0; all entry valid bits 0; FSM to IDLE. Reset applied mid-packet abandons the packet without committing anything.
- Match rule: entry i matches when valid[i] and ((extract_key ^ key[i]) & mask[i] & extract_mask) == 0. Stored mask bit 1 = care. Lowest matching index wins.
- Lookup pipeline, fixed latency 3 cycles:
  - C0: key_valid sampled.
  - C1: match vector registered.
  - C2: priority encode registered.
  - C3: action RAM read out; action_valid=1.
- phv_out is delayed by the same 3 cycles, so it appears with action_valid.
- Back-to-back requests are accepted every cycle.
- Miss: hit=0, hit_index=0, action=0.
- Outside valid cycles, action/phv_out hold their last values.
- Control header is the first beat of each packet:
  - flag [64+:16] must equal 16'hF1F2.
  - module id [112+:8] must equal {STAGE_ID[4:0], LOOKUP_ID[2:0]}.
  - table type [124+:4]: 0 = key/mask write, 1 = action write, 2 = invalidate.
  - index [128+:8].
- FSM states:
  - IDLE: on header beat, go to KEY (type 0), ACT (type 1) or DROP (type 2; index to be invalidated is latched). Go to FWD if flag/id mismatch. Go to DROP if type is unknown or index >= DEPTH.
  - KEY: payload[KEY_LEN-1:0] is captured as the key; go to MASK.
  - MASK: payload is captured as the mask. If tlast: commit key+mask, set valid, go to IDLE. Otherwise commit and go to DROP.
  - ACT: beat counter 0..ACT_BEATS-1, payload packed LSB-first. The write commits on the final counted beat, then go to IDLE if tlast, else DROP.
  - FWD: every beat of the packet, header included, is output on c_m_axis with 1-cycle registered latency, bit-exact. Return to IDLE on tlast.
  - DROP: discard beats until tlast, then IDLE. For type 2, valid[index] clears at tlast.
- Early tlast in KEY/MASK/ACT: the packet is discarded with no write, and the FSM returns to IDLE.
- Beats with tvalid=0 are ignored in every state (no state change).
- A packet consumed by this engine produces nothing on c_m_axis.
- Simultaneous commit and lookup: a lookup sampled in the commit cycle sees the pre-write contents; the next cycle sees the new contents.
- No backpressure: c_s_axis has no tready, and c_m_axis is not throttled.

Decomposition:
- Package lookup_pkg:
  - control field offsets.
  - CTRL_FLAG = 16'hF1F2.
  - table-type codes.
  - FSM state enum.
  - ceil-div function for ACT_BEATS.
- Sub-module tcam_prio_enc (DEPTH-bit match vector -> hit + IDX_W index, lowest index wins). It is also reused by later-stage engines.

Test Plan:
- Program entry 3: key=197'h1, mask all-ones; program action 3 = {ACT_LEN{1'b1}}. Lookup with key 197'h1, extract_mask all-ones, phv_in={48'hFFFFFFFFFFFF,0}. Expect hit=1, hit_index=3, action all-ones, action_valid exactly 3 cycles later, phv_out equal to the input.
- Lookup with key 197'h2 after the above: expect hit=0, action=0, action_valid 3 cycles later.
- Entries 2 and 5 both match the key (entry 2 mask=0): expect hit_index=2. Then invalidate entry 2 via type 2: expect hit_index=5.
- Header with module id 8'h03 (mismatch), 4 beats: expect the same 4 beats on c_m_axis 1 cycle delayed, tlast on the 4th, and no table change.
- Action write with tlast on beat 2 of 3: expect no commit; the old action is still returned. Assert rst_n mid-packet: the next lookup misses on all entries.
- Key commit cycle coincides with key_valid for the same key: expect a miss; the same key one cycle later hits.
